// File: rtl/bsy_pkg.sv
// Shared types for the PS/2 busy-gated capture path.
// Code width and the masked "no data" value live here.
package bsy_pkg;

    localparam int PS2_DATA_W = 8;

    typedef logic [PS2_DATA_W-1:0] ps2_code_t;

    localparam ps2_code_t PS2_NO_DATA = '0;

endpackage

// File: rtl/bsy_capture_fifo_if.sv
// Capture/consume bundle between PS/2 receiver, capture FIFO and decoder.
// slave = the FIFO, master = whoever drives bsy/data_in and consumes codes.
interface bsy_capture_fifo_if
    import bsy_pkg::*;
#(
    parameter int DATA_W = PS2_DATA_W,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              bsy;
    logic [DATA_W-1:0] data_in;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] data_out;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              ovf_clr;

    modport master (
        output bsy, data_in, out_ready, ovf_clr,
        input  out_valid, data_out, count, overflow
    );

    modport slave (
        input  bsy, data_in, out_ready, ovf_clr,
        output out_valid, data_out, count, overflow
    );

endinterface

// File: rtl/bsy_edge_detect.sv
// Busy falling-edge detector producing a one-cycle capture pulse.
// Define BSY_SYNC_EN to add a 2-flop synchroniser ahead of the edge detect.
module bsy_edge_detect
    import bsy_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic bsy,
    output logic cap
);

    logic bsy_s;
    logic bsy_q;

`ifdef BSY_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], bsy};
        end
    end

    assign bsy_s = sync_q[1];
`else
    assign bsy_s = bsy;
`endif

    // History resets low so a bsy already idle at release never captures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bsy_q <= 1'b0;
        end else begin
            bsy_q <= bsy_s;
        end
    end

    assign cap = bsy_q & ~bsy_s;

endmodule

// File: rtl/bsy_capture_fifo.sv
// Captures a PS/2 code on each busy 1->0 edge into a show-ahead FIFO.
// Build option BSY_SYNC_EN synchronises bsy (see bsy_edge_detect).
module bsy_capture_fifo
    import bsy_pkg::*;
#(
    parameter int DATA_W = PS2_DATA_W,
    parameter int DEPTH  = 4
)
(
    input logic               clk,
    input logic               rst_n,
    bsy_capture_fifo_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AW    = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              ovf_q;
    logic              cap;
    logic              valid;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    bsy_edge_detect u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .bsy   (bus.bsy),
        .cap   (cap)
    );

    assign valid = count_q != '0;
    assign full  = count_q == CNT_W'(DEPTH);
    assign pop   = valid & bus.out_ready;
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    assign push  = cap & (~full | pop);
    assign drop  = cap & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = valid;
    assign bus.data_out  = valid ? mem[rd_ptr] : DATA_W'(PS2_NO_DATA);
    assign bus.count     = count_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: doc/bsy_capture_fifo.md
Name: bsy_capture_fifo

Overview:
Sequential, parametrised successor to the PS/2 busy-gated reader. It detects each busy-to-idle (1->0) transition of the PS/2 receiver's bsy line and captures data_in (one scan code) at that moment. Captured codes are queued in a DEPTH-entry FIFO and presented to the keyboard-decode logic over a valid/ready handshake. data_out reads as zero whenever no code is available, so "do not read" still yields 0.

Parameters:
DATA_W, 8, width of each captured code.
DEPTH, 4, FIFO entries; power of two, >= 2.
CNT_W, $clog2(DEPTH+1), derived localparam, width of count; not overridable.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
bsy  in  1  receiver busy; data_in valid only while bsy=0.
data_in  in  DATA_W  received code from the PS/2 receiver.
out_ready  in  1  consumer accepts the head entry this cycle.
out_valid  out  1  FIFO non-empty.
data_out  out  DATA_W  head entry when out_valid=1, else all zeros.
count  out  CNT_W  current occupancy, 0..DEPTH.
overflow  out  1  sticky: a capture was dropped because the FIFO was full.
ovf_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, out_valid=0, data_out=0, overflow=0, bsy history flop=0, sync flops=0.
- bsy_s is the bsy sample used internally (see Optional Feature). bsy_q <= bsy_s each cycle.
- cap = bsy_q & ~bsy_s. This is a single-cycle pulse on each 1->0 transition. A level-low bsy never re-captures.
- After reset with bsy already 0: no capture until bsy goes 1 and then 0.
- On cap, data_in sampled in that same cycle is written at wr_ptr.
- Show-ahead read: data_out = mem[rd_ptr] combinationally when count>0, else 0.
- Latency without sync: the bsy falls before edge N. Capture is written at edge N. out_valid=1 and data_out=code after edge N.
- pop = out_valid & out_ready. The pop takes effect at the clock edge and advances rd_ptr.
- Pointers are DEPTH-modulo and wrap silently. count = pushes minus pops.
- Push with count<DEPTH: accepted.
- Push with count==DEPTH and no pop in the same cycle: data is dropped, overflow<=1, and FIFO contents are unchanged.
- Push and pop in the same cycle, any count including full: both occur, count is unchanged, overflow is not set.
- Pop while empty: impossible, since out_valid=0.
- out_ready is ignored when empty.
- ovf_clr and a drop in the same cycle: set wins, overflow stays 1.
- Reset mid-operation flushes all entries. Memory contents need not be cleared because data_out is masked to 0.

Optional Feature:
Macro BSY_SYNC_EN.
- Defined: bsy passes through a 2-flop synchroniser (reset 0) before edge detection, so bsy_s is bsy delayed 2 clocks. Capture latency grows by 2 cycles. data_in must stay stable for >= 3 cycles after bsy falls; it is sampled on the cap cycle.
- Undefined: bsy_s = bsy directly; bsy is assumed synchronous to clk.

Decomposition:
- Package bsy_pkg:
  - localparam PS2_DATA_W = 8
  - typedef logic [PS2_DATA_W-1:0] ps2_code_t
  - localparam ps2_code_t PS2_NO_DATA = '0, the masked data_out value
- Sub-module bsy_edge_detect:
  - Contains the optional synchroniser plus the history flop.
  - Outputs the cap pulse.
  - Instantiated once.
- The FIFO stays inline.

Test Plan:
1. Reset, bsy=1, data_in=8'hAA held 5 cycles -> out_valid=0, data_out=8'h00, count=0.
2. bsy 1->0 with data_in=8'h15 (Q), out_ready=0 -> one cycle later out_valid=1, data_out=8'h15, count=1. Holding bsy=0 for 10 more cycles keeps count=1.
3. Four bsy pulses with codes 8'h1C, 8'h32, 8'h21, 8'h23 at DEPTH=4, then a fifth code 8'h24 -> count=4, overflow=1, and pops return 1C, 32, 21, 23 in order. Pulse ovf_clr -> overflow=0.
4. FIFO full and out_ready=1 in the same cycle as a capture of 8'h2B -> count stays 4, overflow=0, head advances, and 8'h2B is the last entry popped.
5. Assert rst_n=0 asynchronously with 3 entries queued -> out_valid=0, data_out=0, count=0 immediately. With bsy=0 at release, no capture occurs.
6. BSY_SYNC_EN defined, bsy falls with 8'h15 -> out_valid rises 3 clock edges after the fall, not 1.
